// File: rtl/vga_slot_selector.sv
// vga_slot_selector: VGA timing generator with a row of character slots,
// a tilt-driven highlight cursor (frame-debounced with auto-repeat) and a
// select latch. The glyph bit for the current pixel comes from an external ROM.
// Video timing is parameterised; the defaults give 640x480@60.
module vga_slot_selector #(
  parameter int NUM_SLOTS   = 3,
  parameter int COLOR_W     = 4,
  parameter int CLK_DIV     = 4,
  parameter int HOLD_FRAMES = 8,
  parameter int SLOT_X0     = 128,
  parameter int SLOT_Y0     = 208,
  parameter int SLOT_W      = 64,
  parameter int SLOT_H      = 64,
  parameter int SLOT_GAP    = 16,
  parameter logic [3*COLOR_W-1:0] HI_COLOR = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}},
  parameter logic [3*COLOR_W-1:0] LO_COLOR = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}},
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         tilt_y,
  input  logic               select,
  input  logic               glyph_on,
  output logic [9:0]         pixel_x,
  output logic [9:0]         pixel_y,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               h_sync,
  output logic               v_sync,
  output logic [IW-1:0]      cursor,
  output logic [IW-1:0]      chosen_idx,
  output logic               chosen_valid,
  output logic               frame_start
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int PITCH = SLOT_W + SLOT_GAP;

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] Y_LO    = 16'(SLOT_Y0);
  localparam logic [15:0] Y_HI    = 16'(SLOT_Y0 + SLOT_H);

  typedef enum logic [1:0] {NEUTRAL, HOLD_NEXT, HOLD_PREV} tilt_state_t;

  logic [DW-1:0]        div_q;
  logic                 tick;
  logic [9:0]           h_q, v_q;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 hs_q, vs_q, hs_d, vs_d;
  logic                 frame_start_q;
  logic                 active;
  logic [15:0]          x16, y16;
  logic                 y_in;
  logic [NUM_SLOTS-1:0] hit_vec, cur_vec;

  tilt_state_t          state_q, state_d, dir_state;
  logic [HW-1:0]        hold_q, hold_d, hold_new;
  logic [IW-1:0]        cursor_q, cursor_d;

  logic                 sel_q;
  logic [IW-1:0]        chosen_q;
  logic                 chosen_valid_q;

  assign tick   = (div_q == DW'(CLK_DIV - 1));
  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign x16    = {6'b0, h_q};
  assign y16    = {6'b0, v_q};
  assign y_in   = (y16 >= Y_LO) && (y16 < Y_HI);

  // Pixel-tick divider plus horizontal/vertical raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end
    end
  end

  // One comparator pair per slot; slots never overlap so at most one bit is set.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    localparam logic [15:0] XL = 16'(SLOT_X0 + gi * PITCH);
    localparam logic [15:0] XH = 16'(SLOT_X0 + gi * PITCH + SLOT_W);
    assign hit_vec[gi] = (x16 >= XL) && (x16 < XH) && y_in;
    assign cur_vec[gi] = hit_vec[gi] && (cursor_q == IW'(gi));
  end

  // Colour and sync decisions for the coordinate currently on the counters.
  always_comb begin
    rgb_d = '0;
    if (active && glyph_on) begin
      if (|cur_vec)      rgb_d = HI_COLOR;
      else if (|hit_vec) rgb_d = LO_COLOR;
    end
    hs_d = !((h_q >= HS_START) && (h_q < HS_END));
    vs_d = !((v_q >= VS_START) && (v_q < VS_END));
  end

  // Video outputs register on the pixel tick, one tick behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      if (tick) begin
        rgb_q <= rgb_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
      end
      frame_start_q <= tick && (h_q == H_LAST) && (v_q == V_LAST);
    end
  end

  // Tilt debounce: sample once per frame, step after HOLD_FRAMES same samples.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cursor_d  = cursor_q;
    dir_state = NEUTRAL;
    hold_new  = '0;
    if (frame_start_q) begin
      case (tilt_y)
        2'b01:   dir_state = HOLD_NEXT;
        2'b10:   dir_state = HOLD_PREV;
        default: dir_state = NEUTRAL;
      endcase
      if (dir_state == NEUTRAL) begin
        state_d = NEUTRAL;
        hold_d  = '0;
      end else begin
        hold_new = (dir_state == state_q) ? hold_q + 1'b1 : HW'(1);
        state_d  = dir_state;
        if (hold_new == HW'(HOLD_FRAMES)) begin
          hold_d = '0;
          if (dir_state == HOLD_NEXT)
            cursor_d = (cursor_q == IW'(NUM_SLOTS - 1)) ? '0 : cursor_q + 1'b1;
          else
            cursor_d = (cursor_q == '0) ? IW'(NUM_SLOTS - 1) : cursor_q - 1'b1;
        end else begin
          hold_d = hold_new;
        end
      end
    end
  end

  // Tilt FSM, hold counter and cursor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NEUTRAL;
      hold_q   <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cursor_q <= cursor_d;
    end
  end

  // Select edge detect; latches the cursor as it was before any same-cycle step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q          <= 1'b0;
      chosen_q       <= '0;
      chosen_valid_q <= 1'b0;
    end else begin
      sel_q          <= select;
      chosen_valid_q <= select && !sel_q;
      if (select && !sel_q) chosen_q <= cursor_q;
    end
  end

  assign pixel_x      = h_q;
  assign pixel_y      = v_q;
  assign vga_r        = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_g        = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_b        = rgb_q[COLOR_W-1:0];
  assign h_sync       = hs_q;
  assign v_sync       = vs_q;
  assign cursor       = cursor_q;
  assign chosen_idx   = chosen_q;
  assign chosen_valid = chosen_valid_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_slot_selector.sv
// Testbench for vga_slot_selector: small raster geometry, randomized tilt,
// select and glyph inputs, checked every clk against an arithmetic model.
module tb_vga_slot_selector;

  localparam int NS = 3, CW = 4, CD = 2, HOLD = 3;
  localparam int X0 = 2, Y0 = 4, SW = 8, SH = 8, GAP = 2, PITCH = SW + GAP;
  localparam int HA = 32, HF = 2, HSY = 4, HB = 2, HT = HA + HF + HSY + HB;
  localparam int VA = 16, VF = 2, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
  localparam logic [11:0] HI = 12'hF00, LO = 12'h0F0;

  logic clk = 1'b0, reset;
  logic [1:0] tilt_y;
  logic select, glyph_on;
  logic [9:0] pixel_x, pixel_y;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic h_sync, v_sync, chosen_valid, frame_start;
  logic [1:0] cursor, chosen_idx;

  int n_checks = 0, n_fail = 0;

  // Model state, expressed as elapsed edges/ticks since reset.
  int m_edges, m_ticks, m_cursor, m_chosen, m_run, m_dir, m_samples;
  bit m_sel_prev, m_sampled;
  logic [11:0] exp_rgb;
  bit exp_hs, exp_vs, exp_fs, exp_valid;

  vga_slot_selector #(
    .NUM_SLOTS(NS), .COLOR_W(CW), .CLK_DIV(CD), .HOLD_FRAMES(HOLD),
    .SLOT_X0(X0), .SLOT_Y0(Y0), .SLOT_W(SW), .SLOT_H(SH), .SLOT_GAP(GAP),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .tilt_y(tilt_y), .select(select), .glyph_on(glyph_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_sync(h_sync), .v_sync(v_sync), .cursor(cursor), .chosen_idx(chosen_idx),
    .chosen_valid(chosen_valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0; m_ticks = 0; m_cursor = 0; m_chosen = 0; m_run = 0; m_dir = 0;
    m_sel_prev = 0; m_sampled = 0;
    exp_rgb = '0; exp_hs = 1; exp_vs = 1; exp_fs = 0; exp_valid = 0;
  endtask

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    int h, v, off, slot, dir;
    bit tick;
    h = m_ticks % HT;
    v = (m_ticks / HT) % VT;
    tick = ((m_edges + 1) % CD) == 0;
    m_sampled = exp_fs;
    exp_valid = 0;
    if (select && !m_sel_prev) begin
      m_chosen = m_cursor;
      exp_valid = 1;
    end
    m_sel_prev = select;
    if (tick) begin
      exp_rgb = '0;
      if (h < HA && v < VA && glyph_on && h >= X0 && v >= Y0 && v < Y0 + SH) begin
        off = h - X0;
        slot = off / PITCH;
        if (slot < NS && (off % PITCH) < SW) exp_rgb = (slot == m_cursor) ? HI : LO;
      end
      exp_hs = !(h >= HA + HF && h < HA + HF + HSY);
      exp_vs = !(v >= VA + VF && v < VA + VF + VSY);
    end
    if (m_sampled) begin
      m_samples++;
      dir = (tilt_y == 2'b01) ? 1 : (tilt_y == 2'b10) ? 2 : 0;
      if (dir == 0) m_run = 0;
      else if (dir == m_dir) m_run++;
      else m_run = 1;
      m_dir = dir;
      if (dir != 0 && (m_run % HOLD) == 0)
        m_cursor = (dir == 1) ? (m_cursor + 1) % NS : (m_cursor + NS - 1) % NS;
    end
    m_edges++;
    if (tick) m_ticks++;
    exp_fs = tick && ((m_ticks % (HT * VT)) == 0);
  endtask

  task automatic check_all();
    check_eq("pixel_x", 32'(pixel_x), 32'(m_ticks % HT));
    check_eq("pixel_y", 32'(pixel_y), 32'((m_ticks / HT) % VT));
    check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    check_eq("syncs", 32'({h_sync, v_sync}), 32'({exp_hs, exp_vs}));
    check_eq("frame_start", 32'(frame_start), 32'(exp_fs));
    check_eq("cursor", 32'(cursor), 32'(m_cursor));
    check_eq("chosen_idx", 32'(chosen_idx), 32'(m_chosen));
    check_eq("chosen_valid", 32'(chosen_valid), 32'(exp_valid));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int seg_left, cyc, s0;
    reset = 1; tilt_y = 2'b00; select = 0; glyph_on = 0; m_samples = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset = 0;

    // Held "next": steps at the 3rd and 6th samples; select edge lands on the 6th.
    tilt_y = 2'b01;
    cyc = 0;
    while (m_samples < 7 && cyc < 20000) begin
      step();
      cyc++;
      glyph_on = 1'($urandom_range(0, 1));
      if (m_samples < 4) begin
        if ($urandom_range(0, 255) == 0) select = ~select;
      end else if (m_samples == 4) select = 0;
      else if (m_samples == 5 && exp_fs) select = 1;
    end

    // Random tilt segments of varying length, random select toggling.
    seg_left = 0;
    cyc = 0;
    while (m_samples < 23 && cyc < 40000) begin
      step();
      cyc++;
      glyph_on = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 255) == 0) select = ~select;
      if (m_sampled && seg_left > 0) seg_left--;
      if (seg_left == 0) begin
        tilt_y = 2'($urandom_range(0, 3));
        seg_left = $urandom_range(1, 2 * HOLD + 1);
      end
    end

    // Reach mid-frame, then assert reset between edges.
    cyc = 0;
    while (((m_ticks / HT) % VT) != 12 && cyc < 3000) begin
      step();
      cyc++;
      glyph_on = 1'($urandom_range(0, 1));
    end
    check_eq("reach_mid_frame", 32'((m_ticks / HT) % VT), 32'd12);
    reset = 1;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;
    tilt_y = 2'b10;
    select = 0;

    // After release the first frame_start comes a full frame later.
    s0 = m_samples;
    cyc = 0;
    while (m_samples < s0 + 2 && cyc < 5000) begin
      step();
      cyc++;
      glyph_on = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 127) == 0) select = ~select;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
